mem_access_ctrl: RTL and testbench

Request-side sequencer that sits directly upstream of the embedded-memory block. It converts a valid/ready request stream (read, or bit-masked write) into that block's single-port signals: addr, din, per-bit wen, and 1-cycle-latency dout. Read data returns on a valid/ready response stream that honours backpressure. For power, memory-side address and data are held stable when idle, and wen is zero except in write cycles.

---
 rtl/mem_access_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: valid/ready request sequencer for a single-port memory.
// Optional MEM_ACCESS_CE_EN adds a registered mem_ce output.
module mem_access_ctrl #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 16,
   parameter int RD_LATENCY = 1,
   parameter int RSP_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W-1:0] req_wmask,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic [DATA_W-1:0] mem_wen,
`ifdef MEM_ACCESS_CE_EN
   output logic              mem_ce,
`endif
   input  logic [DATA_W-1:0] mem_dout,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata
);

   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
   localparam logic [PW-1:0] LAST_P  = PW'(RSP_DEPTH - 1);

   logic                  ready_en;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         fifo_cnt;
   logic [RD_LATENCY:0]   rd_pipe;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [DATA_W-1:0]     buf_q [RSP_DEPTH];
   logic                  accept;
   logic                  rd_acc;
   logic                  push;
   logic                  pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_P) ? '0 : p + PW'(1);
   endfunction

   assign req_ready = ready_en && (cnt < DEPTH_C);
   assign accept    = req_valid && req_ready;
   assign rd_acc    = accept && !req_we;
   assign push      = rd_pipe[RD_LATENCY];
   assign rsp_valid = (fifo_cnt != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_rdata = rsp_valid ? buf_q[rd_ptr] : '0;

   // Hold off request acceptance until the first cycle after reset.
   always_ff @(posedge clk) begin
      if (!reset) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   // Memory-side port: addr/din only move on accept, wen pulses on writes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_addr <= '0;
         mem_din  <= '0;
         mem_wen  <= '0;
      end else if (accept) begin
         mem_addr <= req_addr;
         if (req_we) begin
            mem_din <= req_wdata;
            mem_wen <= req_wmask;
         end else begin
            mem_wen <= '0;
         end
      end else begin
         mem_wen <= '0;
      end
   end

`ifdef MEM_ACCESS_CE_EN
   // Clock enable follows each accepted request by one cycle.
   always_ff @(posedge clk) begin
      if (!reset) mem_ce <= 1'b0;
      else        mem_ce <= accept;
   end
`endif

   // Read tag pipeline marks when mem_dout carries a requested word.
   always_ff @(posedge clk) begin
      if (!reset) rd_pipe <= '0;
      else        rd_pipe <= {rd_pipe[RD_LATENCY-1:0], rd_acc};
   end

   // Read credits: outstanding reads not yet handed to the consumer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else begin
         case ({rd_acc, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Response FIFO storage; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) buf_q[wr_ptr] <= mem_dout;
   end

   // Response FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized bench for mem_access_ctrl with
// a behavioural memory and an array/queue reference model.
module tb_mem_access_ctrl;

   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [DW-1:0] req_wmask;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_wen;
   logic [DW-1:0] mem_dout;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
`ifdef MEM_ACCESS_CE_EN
   logic          mem_ce;
`endif

   int total;
   int bad;

   logic [DW-1:0] mem_arr [1024];
   logic [DW-1:0] ref_mem [1024];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] got_q [$];

   int            acc_cnt;
   logic          acc_last;
   logic          acc_we;
   logic [DW-1:0] acc_mask;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_din;

   mem_access_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .RSP_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_wmask(req_wmask),
      .mem_addr(mem_addr),
      .mem_din(mem_din),
      .mem_wen(mem_wen),
`ifdef MEM_ACCESS_CE_EN
      .mem_ce(mem_ce),
`endif
      .mem_dout(mem_dout),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-port memory, one cycle read latency, per-bit write enable.
   always @(posedge clk) begin
      mem_dout <= mem_arr[mem_addr];
      mem_arr[mem_addr] = (mem_arr[mem_addr] & ~mem_wen) | (mem_din & mem_wen);
   end

   // Reference model: writes update the array at accept, reads snapshot it.
   always @(posedge clk) begin
      if (!reset) begin
         exp_q.delete();
         acc_last  = 1'b0;
         last_addr = '0;
         last_din  = '0;
      end else begin
         acc_last = req_valid && req_ready;
         acc_we   = req_we;
         acc_mask = req_wmask;
         if (acc_last) begin
            acc_cnt++;
            last_addr = req_addr;
            if (req_we) begin
               ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask)
                                 | (req_wdata & req_wmask);
               last_din = req_wdata;
            end else begin
               exp_q.push_back(ref_mem[req_addr]);
            end
         end
         if (rsp_valid && rsp_ready) got_q.push_back(rsp_rdata);
      end
   end

   task automatic issue(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] m);
      int n0;
      n0 = acc_cnt;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_wmask = m;
      for (int k = 0; k < 30 && acc_cnt == n0; k++) @(negedge clk);
      req_valid = 1'b0;
      total++;
      if (acc_cnt == n0) begin
         bad++;
         $display("FAIL issue_accept: got %0d accepts, need 1", acc_cnt - n0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         req_valid = 1'($urandom);
         req_we    = 1'($urandom);
         req_addr  = AW'($urandom);
         req_wdata = DW'($urandom);
         req_wmask = DW'($urandom);
         rsp_ready = 1'($urandom);
      end
      @(negedge clk);
      total++;
      if (mem_addr !== '0) begin
         bad++; $display("FAIL rst_addr: got %h need 0", mem_addr);
      end
      total++;
      if (mem_din !== '0) begin
         bad++; $display("FAIL rst_din: got %h need 0", mem_din);
      end
      total++;
      if (mem_wen !== '0) begin
         bad++; $display("FAIL rst_wen: got %h need 0", mem_wen);
      end
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++; $display("FAIL rst_rsp_valid: got %b need 0", rsp_valid);
      end
      total++;
      if (rsp_rdata !== '0) begin
         bad++; $display("FAIL rst_rdata: got %h need 0", rsp_rdata);
      end
      total++;
      if (req_ready !== 1'b0) begin
         bad++; $display("FAIL rst_ready: got %b need 0", req_ready);
      end
`ifdef MEM_ACCESS_CE_EN
      total++;
      if (mem_ce !== 1'b0) begin
         bad++; $display("FAIL rst_ce: got %b need 0", mem_ce);
      end
`endif
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL rst_release_ready: got %b need 1", req_ready);
      end
   endtask

   task automatic test_basic();
      int k;
      got_q.delete();
      issue(1'b1, AW'(1), 16'h1234, 16'hffff);
      total++;
      if (mem_wen !== 16'hffff || mem_addr !== AW'(1) || mem_din !== 16'h1234) begin
         bad++;
         $display("FAIL basic_wr_port: got wen=%h addr=%h din=%h need ffff/1/1234",
                  mem_wen, mem_addr, mem_din);
      end
      issue(1'b0, AW'(1), 16'h0, 16'h0);
      total++;
      if (mem_wen !== '0) begin
         bad++; $display("FAIL basic_wen_once: got %h need 0", mem_wen);
      end
      k = 0;
      while (!rsp_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      total++;
      if (k != 2) begin
         bad++; $display("FAIL basic_latency: got %0d need 2", k);
      end
      total++;
      if (rsp_rdata !== 16'h1234) begin
         bad++; $display("FAIL basic_rdata: got %h need 1234", rsp_rdata);
      end
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++; $display("FAIL basic_single_rsp: got %b need 0", rsp_valid);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_mask();
      logic [DW-1:0] want [2];
      logic [DW-1:0] msk [2];
      want[0] = 16'h1000; want[1] = 16'h1200;
      msk[0]  = 16'hf000; msk[1]  = 16'h0f00;
      for (int i = 0; i < 2; i++) begin
         exp_q.delete();
         got_q.delete();
         issue(1'b1, AW'(2), 16'h1234, msk[i]);
         issue(1'b0, AW'(2), 16'h0, 16'h0);
         for (int k = 0; k < 20 && got_q.size() < 1; k++) @(negedge clk);
         total++;
         if (got_q.size() != 1) begin
            bad++; $display("FAIL mask_rsp_count: got %0d need 1", got_q.size());
         end else if (got_q[0] !== want[i] || exp_q.size() != 1 || exp_q[0] !== want[i]) begin
            bad++; $display("FAIL mask_data: got %h need %h", got_q[0], want[i]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] adr [6];
      logic [DW-1:0] want [6];
      int n0;
      int idx;
      for (int i = 0; i < 6; i++) begin
         adr[i]  = (i % 2 == 0) ? AW'(1) : AW'(2);
         want[i] = (i % 2 == 0) ? 16'h1234 : 16'h1200;
      end
      got_q.delete();
      exp_q.delete();
      rsp_ready = 1'b0;
      n0 = acc_cnt;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = adr[idx];
         @(negedge clk);
         idx = acc_cnt - n0;
      end
      total++;
      if (idx != 4) begin
         bad++; $display("FAIL bp_accepted: got %0d need 4", idx);
      end
      total++;
      if (req_ready !== 1'b0) begin
         bad++; $display("FAIL bp_ready_low: got %b need 0", req_ready);
      end
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234) begin
         bad++; $display("FAIL bp_head: got v=%b d=%h need 1/1234", rsp_valid, rsp_rdata);
      end
      @(negedge clk);
      total++;
      if (rsp_rdata !== 16'h1234) begin
         bad++; $display("FAIL bp_hold: got %h need 1234", rsp_rdata);
      end
      rsp_ready = 1'b1;
      for (int c = 0; c < 30 && idx < 6; c++) begin
         req_addr = adr[idx];
         @(negedge clk);
         idx = acc_cnt - n0;
      end
      req_valid = 1'b0;
      total++;
      if (idx != 6) begin
         bad++; $display("FAIL bp_rest_accepted: got %0d need 6", idx);
      end
      for (int k = 0; k < 30 && got_q.size() < 6; k++) @(negedge clk);
      total++;
      if (got_q.size() != 6 || exp_q.size() != 6) begin
         bad++; $display("FAIL bp_rsp_count: got %0d need 6", got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (got_q[i] !== want[i] || exp_q[i] !== want[i]) begin
               bad++; $display("FAIL bp_order[%0d]: got %h need %h", i, got_q[i], want[i]);
            end
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_stream();
      int n0;
      got_q.delete();
      exp_q.delete();
      rsp_ready = 1'b1;
      n0 = acc_cnt;
      for (int c = 0; c < 20; c++) begin
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = AW'($urandom_range(1, 8));
         @(negedge clk);
         total++;
         if (req_ready !== 1'b1) begin
            bad++; $display("FAIL stream_ready[%0d]: got %b need 1", c, req_ready);
         end
      end
      req_valid = 1'b0;
      total++;
      if (acc_cnt - n0 != 20) begin
         bad++; $display("FAIL stream_accepts: got %0d need 20", acc_cnt - n0);
      end
      for (int c = 0; c < 4; c++) begin
         req_addr  = AW'($urandom);
         req_wdata = DW'($urandom);
         req_we    = 1'($urandom);
         @(negedge clk);
         total++;
         if (mem_addr !== last_addr || mem_din !== last_din || mem_wen !== '0) begin
            bad++;
            $display("FAIL idle_hold[%0d]: got a=%h d=%h w=%h need %h/%h/0",
                     c, mem_addr, mem_din, mem_wen, last_addr, last_din);
         end
      end
      for (int k = 0; k < 30 && got_q.size() < 20; k++) @(negedge clk);
      total++;
      if (got_q.size() != 20 || exp_q.size() != 20) begin
         bad++; $display("FAIL stream_rsp_count: got %0d need 20", got_q.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
               bad++; $display("FAIL stream_data[%0d]: got %h need %h", i, got_q[i], exp_q[i]);
            end
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int seen;
      got_q.delete();
      rsp_ready = 1'b1;
      issue(1'b0, AW'(1), 16'h0, 16'h0);
      issue(1'b0, AW'(2), 16'h0, 16'h0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      total++;
      if (req_ready !== 1'b0) begin
         bad++; $display("FAIL mid_ready_low: got %b need 0", req_ready);
      end
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      total++;
      if (seen != 0 || got_q.size() != 0) begin
         bad++; $display("FAIL mid_lost_rsp: got %0d valid cycles need 0", seen);
      end
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL mid_credit_clear: got %b need 1", req_ready);
      end
      exp_q.delete();
      issue(1'b0, AW'(1), 16'h0, 16'h0);
      for (int k = 0; k < 20 && got_q.size() < 1; k++) @(negedge clk);
      total++;
      if (got_q.size() != 1 || got_q[0] !== 16'h1234) begin
         bad++;
         $display("FAIL mid_next_read: got n=%0d d=%h need 1/1234",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'h0);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random();
      logic [DW-1:0] wen_exp;
      int wen_bad;
      int ce_bad;
      got_q.delete();
      exp_q.delete();
      wen_bad = 0;
      ce_bad  = 0;
      for (int c = 0; c < 300; c++) begin
         req_valid = ($urandom % 4) != 0;
         req_we    = 1'($urandom);
         req_addr  = AW'($urandom_range(1, 8));
         req_wdata = DW'($urandom);
         case ($urandom % 4)
            0:       req_wmask = '0;
            1:       req_wmask = '1;
            default: req_wmask = DW'($urandom);
         endcase
         rsp_ready = ($urandom % 4) != 0;
         @(negedge clk);
         wen_exp = (acc_last && acc_we) ? acc_mask : '0;
         total++;
         if (mem_wen !== wen_exp) begin
            bad++;
            if (wen_bad < 5) $display("FAIL rand_wen[%0d]: got %h need %h", c, mem_wen, wen_exp);
            wen_bad++;
         end
`ifdef MEM_ACCESS_CE_EN
         total++;
         if (mem_ce !== acc_last) begin
            bad++;
            if (ce_bad < 5) $display("FAIL rand_ce[%0d]: got %b need %b", c, mem_ce, acc_last);
            ce_bad++;
         end
`endif
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) @(negedge clk);
      repeat (4) @(negedge clk);
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++; $display("FAIL rand_rsp_count: got %0d need %0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
               bad++; $display("FAIL rand_data[%0d]: got %h need %h", i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      acc_cnt = 0;
      acc_last = 1'b0;
      acc_we = 1'b0;
      acc_mask = '0;
      last_addr = '0;
      last_din = '0;
      for (int i = 0; i < 1024; i++) begin
         mem_arr[i] = '0;
         ref_mem[i] = '0;
      end
      reset = 1'b0;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      req_wmask = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_basic();
      test_mask();
      test_backpressure();
      test_stream();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
